// File: rtl/mips_key_seq.sv
// mips_key_seq: push-button operand sequencer for a small MIPS-style CPU.
// Two asynchronous keys are synchronized, debounced and edge-detected.
// The main key steps through operand entry (data_1, data_2, sel) and then
// fires a one-cycle execute strobe. The PC key loads a PC offset, but only
// while the sequencer is waiting for the first operand.
//
// Build option: define MIPS_KEY_DEBOUNCE_EN to build the counter-based
// debouncers. Without it the stable level simply follows the synchronizer
// and DEBOUNCE_CYCLES has no effect.
//
// Strobe semantics: key_ok and load_pc are registered single-cycle pulses
// with no back-pressure; the CPU must sample them on the cycle they are high.
// The operand registers stay valid until the next entry overwrites them.
module mips_key_seq #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_raw,
  input  logic       key_pc_raw,
  input  logic [7:0] sw_data,
  output logic [7:0] data_1,
  output logic [7:0] data_2,
  output logic [2:0] sel,
  output logic [7:0] offset,
  output logic       key_ok,
  output logic       load_pc,
  output logic [1:0] stage
);

  typedef enum logic [1:0] {
    ENT_D1  = 2'd0,
    ENT_D2  = 2'd1,
    ENT_SEL = 2'd2,
    FIRE    = 2'd3
  } state_t;

  state_t state;

  // Reject out-of-range debounce lengths at elaboration time.
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 1048575) begin : g_bad_debounce
    $error("mips_key_seq: DEBOUNCE_CYCLES must be in 1..2^20-1");
  end

  logic key_s1, key_s2, key_stable, key_stable_d;
  logic pc_s1, pc_s2, pc_stable, pc_stable_d;
  logic key_press, pc_press;

  // Two-flop synchronizers bring the asynchronous buttons into clk's domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_s1 <= 1'b0;
      key_s2 <= 1'b0;
      pc_s1  <= 1'b0;
      pc_s2  <= 1'b0;
    end else begin
      key_s1 <= key_raw;
      key_s2 <= key_s1;
      pc_s1  <= key_pc_raw;
      pc_s2  <= pc_s1;
    end
  end

`ifdef MIPS_KEY_DEBOUNCE_EN
  localparam logic [19:0] CNT_LAST = 20'(DEBOUNCE_CYCLES - 1);

  logic [19:0] key_cnt;
  logic [19:0] pc_cnt;

  // Accept a new level only after it has differed from the stable level for
  // DEBOUNCE_CYCLES consecutive samples; any bounce back restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_cnt    <= '0;
      key_stable <= 1'b0;
      pc_cnt     <= '0;
      pc_stable  <= 1'b0;
    end else begin
      if (key_s2 == key_stable) begin
        key_cnt <= '0;
      end else if (key_cnt == CNT_LAST) begin
        key_cnt    <= '0;
        key_stable <= key_s2;
      end else begin
        key_cnt <= key_cnt + 20'd1;
      end

      if (pc_s2 == pc_stable) begin
        pc_cnt <= '0;
      end else if (pc_cnt == CNT_LAST) begin
        pc_cnt    <= '0;
        pc_stable <= pc_s2;
      end else begin
        pc_cnt <= pc_cnt + 20'd1;
      end
    end
  end
`else
  // No debouncing: the stable level tracks the synchronizer output directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_stable <= 1'b0;
      pc_stable  <= 1'b0;
    end else begin
      key_stable <= key_s2;
      pc_stable  <= pc_s2;
    end
  end
`endif

  // Delayed copies of the stable levels for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_stable_d <= 1'b0;
      pc_stable_d  <= 1'b0;
    end else begin
      key_stable_d <= key_stable;
      pc_stable_d  <= pc_stable;
    end
  end

  assign key_press = key_stable & ~key_stable_d;
  assign pc_press  = pc_stable & ~pc_stable_d;

  // Operand-entry sequencer; the main key always wins over a coincident PC
  // press, and the PC key is honoured only while waiting for data_1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ENT_D1;
      data_1  <= '0;
      data_2  <= '0;
      sel     <= '0;
      offset  <= '0;
      key_ok  <= 1'b0;
      load_pc <= 1'b0;
    end else begin
      key_ok  <= 1'b0;
      load_pc <= 1'b0;
      case (state)
        ENT_D1: begin
          if (key_press) begin
            data_1 <= sw_data;
            state  <= ENT_D2;
          end else if (pc_press) begin
            offset  <= sw_data;
            load_pc <= 1'b1;
          end
        end
        ENT_D2: begin
          if (key_press) begin
            data_2 <= sw_data;
            state  <= ENT_SEL;
          end
        end
        ENT_SEL: begin
          if (key_press) begin
            sel   <= sw_data[2:0];
            state <= FIRE;
          end
        end
        FIRE: begin
          key_ok <= 1'b1;
          state  <= ENT_D1;
        end
        default: state <= ENT_D1;
      endcase
    end
  end

  assign stage = state;

endmodule

// File: tb/tb_mips_key_seq.sv
// Directed bench for mips_key_seq with DEBOUNCE_CYCLES=4. Works with or
// without MIPS_KEY_DEBOUNCE_EN; the capture latency follows the build.
module tb_mips_key_seq;

  localparam int DEB = 4;
`ifdef MIPS_KEY_DEBOUNCE_EN
  localparam int LAT = DEB + 3;
`else
  localparam int LAT = 4;
`endif

  logic       clk;
  logic       rst;
  logic       key_raw;
  logic       key_pc_raw;
  logic [7:0] sw_data;
  logic [7:0] data_1;
  logic [7:0] data_2;
  logic [2:0] sel;
  logic [7:0] offset;
  logic       key_ok;
  logic       load_pc;
  logic [1:0] stage;

  int n_cmp = 0;
  int n_err = 0;
  int ok_pulses = 0;
  int pc_pulses = 0;
  int ok_base;
  int pc_base;

  mips_key_seq #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_raw    (key_raw),
    .key_pc_raw (key_pc_raw),
    .sw_data    (sw_data),
    .data_1     (data_1),
    .data_2     (data_2),
    .sel        (sel),
    .offset     (offset),
    .key_ok     (key_ok),
    .load_pc    (load_pc),
    .stage      (stage)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count cycles each strobe is high, sampled away from the active edge.
  always @(negedge clk) begin
    if (key_ok)  ok_pulses++;
    if (load_pc) pc_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Press the selected keys with sw_data=v, hold 10 cycles, release 10.
  task automatic press(input logic k, input logic p, input logic [7:0] v);
    @(negedge clk);
    sw_data    = v;
    key_raw    = k;
    key_pc_raw = p;
    repeat (10) @(negedge clk);
    key_raw    = 1'b0;
    key_pc_raw = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    rst        = 1'b1;
    key_raw    = 1'b0;
    key_pc_raw = 1'b0;
    sw_data    = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_1", 32'(data_1), 32'h00);
    check("rst_data_2", 32'(data_2), 32'h00);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_offset", 32'(offset), 32'h00);
    check("rst_key_ok", 32'(key_ok), 32'h0);
    check("rst_load_pc", 32'(load_pc), 32'h0);
    check("rst_stage", 32'(stage), 32'h0);

    // First press with exact latency: key high from edge 1.
    @(negedge clk);
    rst     = 1'b0;
    sw_data = 8'h12;
    key_raw = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    #1;
    check("lat_before", 32'(data_1), 32'h00);
    @(posedge clk);
    #1;
    check("lat_after", 32'(data_1), 32'h12);
    check("lat_stage", 32'(stage), 32'h1);
    repeat (5) @(negedge clk);
    key_raw = 1'b0;
    repeat (12) @(negedge clk);

    press(1'b1, 1'b0, 8'h34);
    check("seq_data_2", 32'(data_2), 32'h34);
    check("seq_stage2", 32'(stage), 32'h2);
    ok_base = ok_pulses;
    press(1'b1, 1'b0, 8'h05);
    check("seq_sel", 32'(sel), 32'h5);
    check("seq_key_ok_cycles", 32'(ok_pulses - ok_base), 32'd1);
    check("seq_stage0", 32'(stage), 32'h0);
    check("seq_data_1_held", 32'(data_1), 32'h12);
    check("seq_data_2_held", 32'(data_2), 32'h34);

`ifdef MIPS_KEY_DEBOUNCE_EN
    // A 3-cycle glitch is shorter than the debounce window.
    @(negedge clk);
    sw_data = 8'hEE;
    key_raw = 1'b1;
    repeat (3) @(negedge clk);
    key_raw = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_stage", 32'(stage), 32'h0);
    check("glitch_data_1", 32'(data_1), 32'h12);
    check("glitch_cnt", 32'(dut.key_cnt), 32'h0);
`endif

    // PC press in ENT_D1.
    pc_base = pc_pulses;
    press(1'b0, 1'b1, 8'h80);
    check("pc_offset", 32'(offset), 32'h80);
    check("pc_load_cycles", 32'(pc_pulses - pc_base), 32'd1);
    check("pc_stage", 32'(stage), 32'h0);

    // Both keys together: key wins, PC discarded.
    pc_base = pc_pulses;
    press(1'b1, 1'b1, 8'h7F);
    check("both_data_1", 32'(data_1), 32'h7F);
    check("both_load_pc", 32'(pc_pulses - pc_base), 32'd0);
    check("both_offset", 32'(offset), 32'h80);
    check("both_stage", 32'(stage), 32'h1);

    // PC press outside ENT_D1 is ignored.
    pc_base = pc_pulses;
    press(1'b0, 1'b1, 8'h55);
    check("pc_d2_offset", 32'(offset), 32'h80);
    check("pc_d2_load", 32'(pc_pulses - pc_base), 32'd0);
    check("pc_d2_stage", 32'(stage), 32'h1);

    press(1'b1, 1'b0, 8'h22);
    check("sel_stage", 32'(stage), 32'h2);
    check("sel_data_2", 32'(data_2), 32'h22);

    // Reset mid-sequence with the key held through it.
    @(negedge clk);
    sw_data = 8'h99;
    key_raw = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_data_1", 32'(data_1), 32'h00);
    check("mid_rst_data_2", 32'(data_2), 32'h00);
    check("mid_rst_sel", 32'(sel), 32'h0);
    check("mid_rst_offset", 32'(offset), 32'h00);
    check("mid_rst_stage", 32'(stage), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    #1;
    check("held_before", 32'(data_1), 32'h00);
    @(posedge clk);
    #1;
    check("held_after", 32'(data_1), 32'h99);
    check("held_stage", 32'(stage), 32'h1);
    @(negedge clk);
    key_raw = 1'b0;
    repeat (12) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mips_key_seq.md
MIPS_KEY_SEQ -- requirements
Module: mips_key_seq

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 500000, stable-sample count a key needs before a level change is accepted; legal range 1..2^20-1.
REQ-002 Port: clk  input  1  system clock; all logic on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: key_raw  input  1  operand/execute push-button, asynchronous, active-high.
REQ-005 Port: key_pc_raw  input  1  PC-load push-button, asynchronous, active-high.
REQ-006 Port: sw_data  input  8  slide-switch value, quasi-static.
REQ-007 Port: data_1  output  8  first ALU operand to the CPU, registered.
REQ-008 Port: data_2  output  8  second ALU operand to the CPU, registered.
REQ-009 Port: sel  output  3  ALU operation select to the CPU, registered.
REQ-010 Port: offset  output  8  PC offset to the CPU, registered.
REQ-011 Port: key_ok  output  1  execute strobe to the CPU; single-cycle pulse.
REQ-012 Port: load_pc  output  1  PC-load strobe to the CPU; single-cycle pulse.
REQ-013 Port: stage  output  2  current FSM state, for the board LEDs.

Function
REQ-014 Each key SHALL pass through a 2-flop synchronizer (s1, s2) and then a debouncer that holds a registered "stable" level.
REQ-015 Debouncer: a 20-bit counter SHALL increment on every edge where s2 != stable and clear on every edge where s2 == stable.
REQ-016 Debouncer update: on the edge where s2 != stable and the counter equals DEBOUNCE_CYCLES-1, stable SHALL take s2 and the counter SHALL clear.
REQ-017 Press detection: a press SHALL be stable & ~stable_d, where stable_d is stable delayed one cycle; a release SHALL be debounced identically before another press can occur.
REQ-018 Timing: with key_raw first sampled high at edge 1 and held, the resulting capture SHALL be visible after edge DEBOUNCE_CYCLES+3.
REQ-019 FSM states SHALL be ENT_D1 (encoding 0), ENT_D2 (1), ENT_SEL (2) and FIRE (3), and stage SHALL equal the state encoding.
REQ-020 In ENT_D1, a key press SHALL load data_1<=sw_data and move to ENT_D2.
REQ-021 In ENT_D2, a key press SHALL load data_2<=sw_data and move to ENT_SEL.
REQ-022 In ENT_SEL, a key press SHALL load sel<=sw_data[2:0] and move to FIRE.
REQ-023 FIRE SHALL last exactly one cycle: key_ok SHALL be 1 for exactly one cycle after the exit edge, and the FSM SHALL return to ENT_D1.
REQ-024 A PC press in ENT_D1 SHALL load offset<=sw_data and pulse load_pc for exactly one cycle, with the state unchanged.
REQ-025 A PC press in any state other than ENT_D1 SHALL be ignored.
REQ-026 If key and PC presses occur in the same cycle, the key press SHALL be processed and the PC press SHALL be discarded.
REQ-027 Registers not named in the current action SHALL hold their value, and the operands SHALL stay held after FIRE for CPU observation.

Reset
REQ-028 On rst=1 at a clock edge, the following SHALL clear to 0: state (ENT_D1), data_1, data_2, sel, offset, key_ok, load_pc, both synchronizers, both stable levels, both stable_d, and both counters.
REQ-029 Reset SHALL abort an operation mid-sequence, and already-entered operands SHALL be lost.
REQ-030 A key held through reset release SHALL register as a new press DEBOUNCE_CYCLES+3 edges after the first post-reset edge.

Configuration
REQ-031 Macro MIPS_KEY_DEBOUNCE_EN: when defined, the debouncer of REQ-015..016 SHALL be built.
REQ-032 When MIPS_KEY_DEBOUNCE_EN is undefined, the counters SHALL be removed and stable<=s2 every edge, giving capture after edge 4 (equivalent to DEBOUNCE_CYCLES=1).
REQ-033 The parameter SHALL have no effect when the counters are removed.

Verification (DEBOUNCE_CYCLES=4, macro defined)
REQ-034 Three clean presses (sw_data 0x12, 0x34, 0x05), each held 10 cycles and released 10 -> data_1=0x12, data_2=0x34, sel=5, key_ok high exactly one cycle, stage back to 0.
REQ-035 key_raw glitch high for 3 cycles -> no state change, counter returns to 0.
REQ-036 PC press with sw_data=0x80 in ENT_D1 -> offset=0x80, one-cycle load_pc, stage stays 0; PC press in ENT_D2 -> offset unchanged, no load_pc.
REQ-037 Both keys pressed on the same edge in ENT_D1, sw_data=0x7F -> data_1=0x7F, load_pc stays 0, offset unchanged.
REQ-038 rst pulsed while in ENT_SEL -> all outputs 0, stage 0; a held key is then accepted as a press DEBOUNCE_CYCLES+3 edges later.
REQ-039 Macro undefined, key_raw high at edge 1 -> data_1 captured after edge 4.
